// File: rtl/cv32e40p_perm_fault_tracker_ft.sv
// Permanent-fault tracker for the four ALU and four MULT replicas.
// Counts voter disagreements per replica and raises sticky faulty bits.
//
// Parameters:
//   CNT_W      width of each per-replica error counter
//   THRESHOLD  count at which a replica is declared faulty (1 .. 2^CNT_W-1)
// Ports:
//   clk, rst_n               clock, async active-low reset
//   clear_i                  sync clear of all counters and fault bits
//   alu_valid_i              ALU vote happened this cycle
//   alu_mismatch_i [3:0]     ALU replica disagreed with majority
//   alu_active_i [3:0]       ALU replicas clocked for this op
//   mult_valid_i             MULT vote happened this cycle
//   mult_mismatch_i [3:0]    MULT replica disagreed with majority
//   mult_active_i [3:0]      MULT replicas clocked for this op
//   permanent_faulty_alu_o   sticky faulty flags, ALU replicas
//   permanent_faulty_mult_o  sticky faulty flags, MULT replicas
//   new_fault_o              one-cycle pulse on any new fault bit
//   vote_fail_o              one-cycle pulse on an unusable vote
// Build option:
//   FT_FAULT_DECAY_EN        clean votes decrement the counter
module cv32e40p_perm_fault_tracker_ft #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned THRESHOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       alu_valid_i,
    input  logic [3:0] alu_mismatch_i,
    input  logic [3:0] alu_active_i,
    input  logic       mult_valid_i,
    input  logic [3:0] mult_mismatch_i,
    input  logic [3:0] mult_active_i,
    output logic [3:0] permanent_faulty_alu_o,
    output logic [3:0] permanent_faulty_mult_o,
    output logic       new_fault_o,
    output logic       vote_fail_o
);

    if (THRESHOLD < 1 || THRESHOLD > (2 ** CNT_W) - 1) begin : g_bad_threshold
        $error("THRESHOLD out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

    // Replicas 0..3 are ALU, 4..7 are MULT.
    logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]            faulty_q, faulty_d;
    logic                  new_fault_q, new_fault_d;
    logic                  vote_fail_q, vote_fail_d;

    logic [1:0]      grp_valid;
    logic [1:0][3:0] grp_mismatch;
    logic [1:0][3:0] grp_active;
    logic [1:0][3:0] grp_avail;
    logic [1:0][3:0] grp_mm;
    logic [1:0]      grp_bypass;
    logic [1:0]      grp_fail;
    logic [1:0]      grp_upd;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    always_comb begin
        grp_valid    = {mult_valid_i, alu_valid_i};
        grp_mismatch = {mult_mismatch_i, alu_mismatch_i};
        grp_active   = {mult_active_i, alu_active_i};
        grp_avail    = '0;
        grp_mm       = '0;
        grp_bypass   = '0;
        grp_fail     = '0;
        grp_upd      = '0;
        cnt_d        = cnt_q;
        faulty_d     = faulty_q;

        for (int g = 0; g < 2; g++) begin
            grp_avail[g]  = grp_active[g] & ~faulty_q[g*4 +: 4];
            grp_mm[g]     = grp_mismatch[g] & grp_avail[g];
            // Fewer than two live replicas: no majority to judge against.
            grp_bypass[g] = popcnt4(grp_avail[g]) < 3'd2;
            // Two or more dissenters: the majority itself is suspect.
            grp_fail[g]   = grp_valid[g] && !grp_bypass[g]
                            && (popcnt4(grp_mm[g]) >= 3'd2);
            grp_upd[g]    = grp_valid[g] && !grp_bypass[g] && !grp_fail[g];

            for (int r = 0; r < 4; r++) begin
                if (grp_upd[g] && grp_avail[g][r]) begin
                    if (grp_mm[g][r]) begin
                        if (cnt_q[g*4+r] != CNT_MAX)
                            cnt_d[g*4+r] = cnt_q[g*4+r] + 1'b1;
                        if (cnt_d[g*4+r] >= THR)
                            faulty_d[g*4+r] = 1'b1;
                    end else begin
`ifdef FT_FAULT_DECAY_EN
                        if (cnt_q[g*4+r] != '0)
                            cnt_d[g*4+r] = cnt_q[g*4+r] - 1'b1;
`else
                        cnt_d[g*4+r] = cnt_q[g*4+r];
`endif
                    end
                end
            end
        end

        vote_fail_d = |grp_fail;
        new_fault_d = |(faulty_d & ~faulty_q);

        if (clear_i) begin
            cnt_d       = '0;
            faulty_d    = '0;
            vote_fail_d = 1'b0;
            new_fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            faulty_q    <= '0;
            new_fault_q <= 1'b0;
            vote_fail_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            faulty_q    <= faulty_d;
            new_fault_q <= new_fault_d;
            vote_fail_q <= vote_fail_d;
        end
    end

    assign permanent_faulty_alu_o  = faulty_q[3:0];
    assign permanent_faulty_mult_o = faulty_q[7:4];
    assign new_fault_o             = new_fault_q;
    assign vote_fail_o             = vote_fail_q;

endmodule
